// File: rtl/alu_instr_sequencer.sv
// Moore control sequencer for register-register ALU instructions: fetch (T0-T2)
// followed by a class-dependent execute sequence (T3-T6) on the phase-1 datapath.
module alu_instr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [IR_W-1:0]     ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                ZLowOut,
  output logic                ZHighOut,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic [3:0]          alu_op,
  output logic                done,
  output logic                illegal,
  output logic [3:0]          state
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_T0      = 4'd1;
  localparam logic [3:0] S_T1      = 4'd2;
  localparam logic [3:0] S_T2      = 4'd3;
  localparam logic [3:0] S_T3      = 4'd4;
  localparam logic [3:0] S_T4      = 4'd5;
  localparam logic [3:0] S_T5      = 4'd6;
  localparam logic [3:0] S_T6      = 4'd7;
  localparam logic [3:0] S_ILLEGAL = 4'd15;

  logic [3:0]          state_q;
  logic [3:0]          state_nxt;
  logic [4:0]          opcode;
  logic [RW-1:0]       ra;
  logic [RW-1:0]       rb;
  logic [RW-1:0]       rc;
  logic [NUM_REGS-1:0] ra_sel;
  logic [NUM_REGS-1:0] rb_sel;
  logic [NUM_REGS-1:0] rc_sel;
  logic                is_bin;
  logic                is_md;
  logic                is_un;
  logic                is_legal;
  logic [3:0]          op_sel;
  logic [3:0]          fin_state;
  logic                unused_ir_bits;

  assign opcode = ir[IR_W-1 -: 5];
  assign ra     = ir[IR_W-6 -: RW];
  assign rb     = ir[IR_W-6-RW -: RW];
  assign rc     = ir[IR_W-6-2*RW -: RW];
  assign unused_ir_bits = ^ir[IR_W-6-3*RW:0];

  assign ra_sel = {{(NUM_REGS-1){1'b0}}, 1'b1} << ra;
  assign rb_sel = {{(NUM_REGS-1){1'b0}}, 1'b1} << rb;
  assign rc_sel = {{(NUM_REGS-1){1'b0}}, 1'b1} << rc;

  // Opcode -> instruction class and ALU function
  always_comb begin
    is_bin = 1'b0;
    is_md  = 1'b0;
    is_un  = 1'b0;
    op_sel = 4'd0;
    case (opcode)
      5'b00011: begin is_bin = 1'b1; op_sel = 4'd0;  end
      5'b00100: begin is_bin = 1'b1; op_sel = 4'd1;  end
      5'b00101: begin is_bin = 1'b1; op_sel = 4'd2;  end
      5'b00110: begin is_bin = 1'b1; op_sel = 4'd3;  end
      5'b00111: begin is_bin = 1'b1; op_sel = 4'd4;  end
      5'b01000: begin is_bin = 1'b1; op_sel = 4'd5;  end
      5'b01001: begin is_bin = 1'b1; op_sel = 4'd6;  end
      5'b01010: begin is_bin = 1'b1; op_sel = 4'd7;  end
      5'b01011: begin is_bin = 1'b1; op_sel = 4'd8;  end
      5'b01111: begin is_md  = 1'b1; op_sel = 4'd9;  end
      5'b10000: begin is_md  = 1'b1; op_sel = 4'd10; end
      5'b10001: begin is_un  = 1'b1; op_sel = 4'd11; end
      5'b10010: begin is_un  = 1'b1; op_sel = 4'd12; end
      default:  begin op_sel = 4'd0; end
    endcase
  end

  assign is_legal  = is_bin | is_md | is_un;
  // The done cycle chains straight into the next fetch when run is held
  assign fin_state = run ? S_T0 : S_IDLE;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:    state_nxt = run ? S_T0 : S_IDLE;
      S_T0:      state_nxt = S_T1;
      S_T1:      state_nxt = S_T2;
      S_T2:      state_nxt = S_T3;
      S_T3:      state_nxt = is_legal ? S_T4 : S_ILLEGAL;
      S_T4:      state_nxt = is_un ? fin_state : S_T5;
      S_T5:      state_nxt = is_bin ? fin_state : S_T6;
      S_T6:      state_nxt = fin_state;
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  assign state = state_q;

  // Strobe decode from state and ir only; clear drops everything via state_q
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    r_in     = '0;
    r_out    = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    alu_op   = 4'd0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        alu_op = op_sel;
        if (is_legal) begin
          r_out  = rb_sel;
          ZLowIn = is_un;
          Yin    = ~is_un;
        end
      end
      S_T4: begin
        alu_op = op_sel;
        if (is_un) begin
          ZLowOut = 1'b1;
          r_in    = ra_sel;
          done    = 1'b1;
        end else if (is_legal) begin
          r_out   = rc_sel;
          ZLowIn  = 1'b1;
          ZHighIn = is_md;
        end
      end
      S_T5: begin
        alu_op = op_sel;
        if (is_bin) begin
          ZLowOut = 1'b1;
          r_in    = ra_sel;
          done    = 1'b1;
        end else if (is_md) begin
          ZLowOut = 1'b1;
          LOin    = 1'b1;
        end
      end
      S_T6: begin
        alu_op = op_sel;
        if (is_md) begin
          ZHighOut = 1'b1;
          HIin     = 1'b1;
          done     = 1'b1;
        end
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
